dual_port_bram: RTL and testbench

Dual-port, byte-writable block RAM for the serial-bus masters and slaves: two independent request ports with registered reads, configurable read latency and a controlled cross-port read-during-write policy. It also has a hardware clear sequencer that zeroes the whole array on request. It replaces the single-port master memory wherever the bus engine and a local controller must access the buffer concurrently.

---
 rtl/bram_pkg.sv | 18 +
 rtl/bram_read_pipe.sv | 43 ++++
 rtl/dual_port_bram.sv | 185 ++++++++++++++++++
 tb/tb_dual_port_bram.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared types and helpers for the dual-port byte-writable block RAM.
package bram_pkg;

    typedef enum logic {
        READ_FIRST,
        WRITE_FIRST
    } write_mode_e;

    typedef enum logic {
        IDLE,
        CLEAR
    } clr_state_e;

    function automatic int calc_be(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/bram_read_pipe.sv
// Delay line for read results; q only advances alongside a valid so it holds between results.
module bram_read_pipe #(
    parameter int DEPTH = 0,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic [WIDTH-1:0] d_in,
    input  logic             v_in,
    output logic [WIDTH-1:0] d_out,
    output logic             v_out
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign d_out = d_in;
            assign v_out = v_in;
        end else begin : g_dly
            logic [WIDTH-1:0] d_r [DEPTH];
            logic             v_r [DEPTH];

            always_ff @(posedge clk or negedge rstN) begin
                if (!rstN) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        d_r[i] <= '0;
                        v_r[i] <= 1'b0;
                    end
                end else begin
                    v_r[0] <= v_in;
                    if (v_in) d_r[0] <= d_in;
                    for (int i = 1; i < DEPTH; i++) begin
                        v_r[i] <= v_r[i-1];
                        if (v_r[i-1]) d_r[i] <= d_r[i-1];
                    end
                end
            end

            assign d_out = d_r[DEPTH-1];
            assign v_out = v_r[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/dual_port_bram.sv
// Dual-port byte-writable RAM with registered reads, cross-port write policy and a zero-fill sequencer.
//   state | meaning
//   IDLE  | normal port access
//   CLEAR | writing zero to one word per cycle via port A, ports ignored
module dual_port_bram
    import bram_pkg::*;
#(
    parameter int          MEMORY_DEPTH  = 4096,
    parameter int          DATA_WIDTH    = 16,
    parameter int          BYTE_WIDTH    = 8,
    parameter int          READ_LATENCY  = 1,
    parameter write_mode_e WRITE_MODE    = READ_FIRST,
    parameter              MEM_INIT_FILE = "",
    localparam int         AW            = $clog2(MEMORY_DEPTH),
    localparam int         BE            = calc_be(DATA_WIDTH, BYTE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  en_a,
    input  logic                  wr_a,
    input  logic [BE-1:0]         be_a,
    input  logic [AW-1:0]         address_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] q_a,
    output logic                  q_valid_a,
    input  logic                  en_b,
    input  logic                  wr_b,
    input  logic [BE-1:0]         be_b,
    input  logic [AW-1:0]         address_b,
    input  logic [DATA_WIDTH-1:0] data_b,
    output logic [DATA_WIDTH-1:0] q_b,
    output logic                  q_valid_b,
    input  logic                  clear_req,
    output logic                  busy,
    output logic                  collision
);

    generate
        if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
            $error("dual_port_bram: DATA_WIDTH must be a multiple of BYTE_WIDTH");
        end
        if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
            $error("dual_port_bram: READ_LATENCY must be 1 or 2");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

    clr_state_e    state, state_nxt;
    logic [AW-1:0] clr_addr, clr_addr_nxt;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= IDLE;
            clr_addr <= '0;
        end else begin
            state    <= state_nxt;
            clr_addr <= clr_addr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        clr_addr_nxt = clr_addr;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_nxt    = CLEAR;
                    clr_addr_nxt = '0;
                end
            end
            CLEAR: begin
                if (clr_addr == AW'(MEMORY_DEPTH - 1)) begin
                    state_nxt    = IDLE;
                    clr_addr_nxt = '0;
                end else begin
                    clr_addr_nxt = clr_addr + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == CLEAR);

    logic a_in_rng, b_in_rng, a_we, b_we, a_rd, b_rd;

    assign a_in_rng = ({1'b0, address_a} < (AW+1)'(MEMORY_DEPTH));
    assign b_in_rng = ({1'b0, address_b} < (AW+1)'(MEMORY_DEPTH));
    assign a_we     = en_a & wr_a & ~busy & a_in_rng & (|be_a);
    assign b_we     = en_b & wr_b & ~busy & b_in_rng & (|be_b);
    assign a_rd     = en_a & ~wr_a & ~busy;
    assign b_rd     = en_b & ~wr_b & ~busy;

    // The clear sequencer borrows the port-A write path.
    logic                  wa_en;
    logic [AW-1:0]         wa_addr;
    logic [BE-1:0]         wa_be;
    logic [DATA_WIDTH-1:0] wa_data;

    assign wa_en   = busy | a_we;
    assign wa_addr = busy ? clr_addr : address_a;
    assign wa_be   = busy ? '1 : be_a;
    assign wa_data = busy ? '0 : data_a;

    // Port A is written last so its lanes win on a same-address collision.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE; i++) begin
            if (b_we && be_b[i])
                mem[address_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= data_b[i*BYTE_WIDTH +: BYTE_WIDTH];
            if (wa_en && wa_be[i])
                mem[wa_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wa_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    logic [DATA_WIDTH-1:0] rd_word_a, rd_word_b;

    always_comb begin
        rd_word_a = a_in_rng ? mem[address_a] : '0;
        if (WRITE_MODE == WRITE_FIRST && a_in_rng && b_we && address_b == address_a) begin
            for (int i = 0; i < BE; i++)
                if (be_b[i]) rd_word_a[i*BYTE_WIDTH +: BYTE_WIDTH] = data_b[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    always_comb begin
        rd_word_b = b_in_rng ? mem[address_b] : '0;
        if (WRITE_MODE == WRITE_FIRST && b_in_rng && wa_en && wa_addr == address_b) begin
            for (int i = 0; i < BE; i++)
                if (wa_be[i]) rd_word_b[i*BYTE_WIDTH +: BYTE_WIDTH] = wa_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    logic [DATA_WIDTH-1:0] r1_q_a, r1_q_b, p_q_a, p_q_b;
    logic                  r1_v_a, r1_v_b, p_v_a, p_v_b;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r1_q_a    <= '0;
            r1_v_a    <= 1'b0;
            r1_q_b    <= '0;
            r1_v_b    <= 1'b0;
            collision <= 1'b0;
        end else begin
            r1_v_a    <= a_rd;
            r1_v_b    <= b_rd;
            if (a_rd) r1_q_a <= rd_word_a;
            if (b_rd) r1_q_b <= rd_word_b;
            collision <= a_we & b_we & (address_a == address_b);
        end
    end

    bram_read_pipe #(.DEPTH(READ_LATENCY - 1), .WIDTH(DATA_WIDTH)) u_pipe_a (
        .clk   (clk),
        .rstN  (rstN),
        .d_in  (r1_q_a),
        .v_in  (r1_v_a),
        .d_out (p_q_a),
        .v_out (p_v_a)
    );

    bram_read_pipe #(.DEPTH(READ_LATENCY - 1), .WIDTH(DATA_WIDTH)) u_pipe_b (
        .clk   (clk),
        .rstN  (rstN),
        .d_in  (r1_q_b),
        .v_in  (r1_v_b),
        .d_out (p_q_b),
        .v_out (p_v_b)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            q_a       <= '0;
            q_valid_a <= 1'b0;
            q_b       <= '0;
            q_valid_b <= 1'b0;
        end else begin
            q_valid_a <= p_v_a;
            q_valid_b <= p_v_b;
            if (p_v_a) q_a <= p_q_a;
            if (p_v_b) q_b <= p_q_b;
        end
    end

endmodule

// File: tb/tb_dual_port_bram.sv
// Directed bench: dut 0 is depth 16 / latency 1 / READ_FIRST, dut 1 is depth 4092 / latency 2 / WRITE_FIRST.
module tb_dual_port_bram;
    import bram_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rstN;
    logic [1:0]       en_a, wr_a, en_b, wr_b, clear_req, qv_a, qv_b, busy, collision;
    logic [1:0][1:0]  be_a, be_b;
    logic [1:0][11:0] addr_a, addr_b;
    logic [1:0][15:0] data_a, data_b, q_a, q_b;
    int n_cmp = 0;
    int n_err = 0;
    int cyc;

    dual_port_bram #(.MEMORY_DEPTH(16), .READ_LATENCY(1), .WRITE_MODE(READ_FIRST)) u_dut0 (
        .clk(clk), .rstN(rstN),
        .en_a(en_a[0]), .wr_a(wr_a[0]), .be_a(be_a[0]), .address_a(addr_a[0][3:0]), .data_a(data_a[0]),
        .q_a(q_a[0]), .q_valid_a(qv_a[0]),
        .en_b(en_b[0]), .wr_b(wr_b[0]), .be_b(be_b[0]), .address_b(addr_b[0][3:0]), .data_b(data_b[0]),
        .q_b(q_b[0]), .q_valid_b(qv_b[0]),
        .clear_req(clear_req[0]), .busy(busy[0]), .collision(collision[0])
    );

    dual_port_bram #(.MEMORY_DEPTH(4092), .READ_LATENCY(2), .WRITE_MODE(WRITE_FIRST)) u_dut1 (
        .clk(clk), .rstN(rstN),
        .en_a(en_a[1]), .wr_a(wr_a[1]), .be_a(be_a[1]), .address_a(addr_a[1]), .data_a(data_a[1]),
        .q_a(q_a[1]), .q_valid_a(qv_a[1]),
        .en_b(en_b[1]), .wr_b(wr_b[1]), .be_b(be_b[1]), .address_b(addr_b[1]), .data_b(data_b[1]),
        .q_b(q_b[1]), .q_valid_b(qv_b[1]),
        .clear_req(clear_req[1]), .busy(busy[1]), .collision(collision[1])
    );

    function automatic int lat(input int d);
        return d + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int d);
        en_a[d] = 1'b0; wr_a[d] = 1'b0; be_a[d] = 2'b00;
        en_b[d] = 1'b0; wr_b[d] = 1'b0; be_b[d] = 2'b00;
    endtask

    task automatic set_wa(input int d, input logic [11:0] ad, input logic [15:0] dt, input logic [1:0] be);
        en_a[d] = 1'b1; wr_a[d] = 1'b1; addr_a[d] = ad; data_a[d] = dt; be_a[d] = be;
    endtask

    task automatic set_wb(input int d, input logic [11:0] ad, input logic [15:0] dt, input logic [1:0] be);
        en_b[d] = 1'b1; wr_b[d] = 1'b1; addr_b[d] = ad; data_b[d] = dt; be_b[d] = be;
    endtask

    task automatic set_ra(input int d, input logic [11:0] ad);
        en_a[d] = 1'b1; wr_a[d] = 1'b0; addr_a[d] = ad;
    endtask

    task automatic set_rb(input int d, input logic [11:0] ad);
        en_b[d] = 1'b1; wr_b[d] = 1'b0; addr_b[d] = ad;
    endtask

    task automatic rd(input int d, input bit pb, input logic [11:0] ad, input logic [15:0] exp, input string tag);
        if (pb) set_rb(d, ad); else set_ra(d, ad);
        tick();
        idle(d);
        repeat (lat(d)) tick();
        chk({tag, "_valid"}, pb ? qv_b[d] : qv_a[d], 16'd1);
        chk(tag, pb ? q_b[d] : q_a[d], exp);
    endtask

    task automatic preload0();
        for (int k = 0; k < 16; k++) begin
            set_wa(0, 12'(k), 16'h0100 + 16'(k), 2'b11);
            tick();
        end
        idle(0);
    endtask

    // Streams reads of all 16 words of dut 0 on port B; words below keep_from expect 0.
    task automatic stream_b0(input int keep_from, input string tag);
        logic [15:0] e;
        for (int k = 0; k <= 16; k++) begin
            if (k < 16) set_rb(0, 12'(k)); else idle(0);
            tick();
            if (k >= 1) begin
                e = (k - 1 < keep_from) ? 16'h0000 : 16'h0100 + 16'(k - 1);
                chk($sformatf("%s_valid%0d", tag, k - 1), qv_b[0], 16'd1);
                chk($sformatf("%s_q%0d", tag, k - 1), q_b[0], e);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rstN = 1'b0; clear_req = '0;
        addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;
        idle(0); idle(1);
        tick(); tick();
        for (int d = 0; d < 2; d++) begin
            chk("rst_q_a", q_a[d], 16'h0);
            chk("rst_q_b", q_b[d], 16'h0);
            chk("rst_qv_a", qv_a[d], 16'h0);
            chk("rst_qv_b", qv_b[d], 16'h0);
            chk("rst_busy", busy[d], 16'h0);
            chk("rst_collision", collision[d], 16'h0);
        end
        rstN = 1'b1;
        tick();

        for (int d = 0; d < 2; d++) begin
            set_wa(d, 12'd5, 16'hABCD, 2'b11);
            tick();
            chk("wr_no_qv", qv_a[d], 16'h0);
            set_wa(d, 12'd5, 16'h1200, 2'b10);
            tick();
            idle(d);
            set_rb(d, 12'd5);
            tick();
            idle(d);
            chk("bw_qv_early", qv_b[d], 16'h0);
            if (lat(d) == 2) begin
                tick();
                chk("bw_qv_l2_early", qv_b[d], 16'h0);
            end
            tick();
            chk("bw_qv", qv_b[d], 16'h1);
            chk("bw_q", q_b[d], 16'h12CD);
            tick();
            chk("bw_qv_pulse", qv_b[d], 16'h0);
            chk("bw_q_hold", q_b[d], 16'h12CD);

            set_wa(d, 12'd3, 16'h0001, 2'b11);
            tick();
            set_wa(d, 12'd3, 16'h5555, 2'b11);
            set_rb(d, 12'd3);
            tick();
            idle(d);
            chk("rdw_no_collision", collision[d], 16'h0);
            repeat (lat(d)) tick();
            chk("rdw_qv", qv_b[d], 16'h1);
            chk("rdw_q", q_b[d], (d == 0) ? 16'h0001 : 16'h5555);
            rd(d, 1'b1, 12'd3, 16'h5555, "rdw_after");

            set_wa(d, 12'd9, 16'h1111, 2'b01);
            set_wb(d, 12'd9, 16'h2222, 2'b11);
            tick();
            idle(d);
            chk("collision_pulse", collision[d], 16'h1);
            tick();
            chk("collision_clear", collision[d], 16'h0);
            rd(d, 1'b0, 12'd9, 16'h2211, "coll_rd");
        end

        set_wa(1, 12'd4091, 16'h7777, 2'b11);
        tick();
        set_wa(1, 12'd4095, 16'hBEEF, 2'b11);
        tick();
        idle(1);
        rd(1, 1'b1, 12'd4091, 16'h7777, "last_word_rd");
        rd(1, 1'b0, 12'd4095, 16'h0000, "oor_rd");

        preload0();
        clear_req[0] = 1'b1;
        tick();
        clear_req[0] = 1'b0;
        chk("clr_busy_start", busy[0], 16'h1);
        cyc = 0;
        for (int i = 0; i < 40 && busy[0]; i++) begin
            if (i == 3) set_wb(0, 12'd0, 16'hFFFF, 2'b11);
            else if (i == 4) begin idle(0); set_ra(0, 12'd7); end
            else idle(0);
            cyc++;
            tick();
            if (i == 5) chk("clr_no_qv", qv_a[0], 16'h0);
        end
        idle(0);
        chk("clr_busy_cycles", 16'(cyc), 16'd16);
        chk("clr_busy_end", busy[0], 16'h0);
        stream_b0(16, "clr");

        preload0();
        clear_req[0] = 1'b1;
        tick();
        clear_req[0] = 1'b0;
        repeat (6) tick();
        rstN = 1'b0;
        #1;
        chk("rstclr_busy_now", busy[0], 16'h0);
        tick();
        rstN = 1'b1;
        tick();
        chk("rstclr_no_resume", busy[0], 16'h0);
        stream_b0(6, "rstclr");

        set_rb(1, 12'd5);
        tick();
        idle(1);
        rstN = 1'b0;
        #1;
        chk("flush_q_b", q_b[1], 16'h0);
        chk("flush_qv_now", qv_b[1], 16'h0);
        tick();
        rstN = 1'b1;
        tick();
        chk("flush_qv_1", qv_b[1], 16'h0);
        tick();
        chk("flush_qv_2", qv_b[1], 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
